// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 mouse packet path.
//   state_t    - packet sequencer state encoding
//   SYNC_BIT.. - bit positions inside the first (status) byte of a packet
//   PKT_BYTES  - bytes per standard movement packet
package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_B1     = 2'd1,
    S_B2     = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  localparam int SYNC_BIT  = 3;
  localparam int XSIGN     = 4;
  localparam int YSIGN     = 5;
  localparam int XOVF      = 6;
  localparam int YOVF      = 7;
  localparam int PKT_BYTES = 3;

endpackage

// File: rtl/ps2_timeout_counter.sv
// ps2_timeout_counter: inter-byte watchdog, down-counter with terminal-count compare.
//   clk, rst  - clock, async active-low reset
//   load      - restart the window (TIMEOUT_CYCLES-1 cycles to expiry)
//   clear     - force the count to 0 (lower priority than load)
//   run       - count enable; expire is only reported while running
//   expire    - high during the last cycle of the window
module ps2_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(TIMEOUT_CYCLES - 1);
    end else if (clear) begin
      cnt <= '0;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = run && (cnt == '0);

endmodule

// File: rtl/ps2_packet_sequencer.sv
// ps2_packet_sequencer: assembles and validates 3-byte PS/2 mouse packets.
//   clk, rst             - clock, async active-low reset
//   en                   - enable; low drops any partial packet
//   clr_cnt              - synchronous clear of pkt_cnt / err_cnt
//   byte_valid/byte_data - byte strobe and data from the PS/2 receiver
//   x_axis, y_axis       - 9-bit signed deltas of the last accepted packet
//   buttons              - {M, R, L} of the last accepted packet
//   package_done         - one-cycle pulse, outputs valid while high
//   pkt_cnt, err_cnt     - accepted packets (wraps), error events (saturates)
//
// state    | meaning
// S_IDLE   | waiting for a status byte with the sync bit set
// S_B1     | status byte held, waiting for X byte
// S_B2     | X byte held, waiting for Y byte
// S_COMMIT | full packet held, outputs load at the end of this cycle
module ps2_packet_sequencer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_cnt,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic [8:0]       x_axis,
  output logic [8:0]       y_axis,
  output logic [2:0]       buttons,
  output logic             package_done,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [7:0]       err_cnt
);

  state_t     state, next_state;
  logic [7:0] b0, b1, b2;
  logic       lat0, lat1, lat2;
  logic       commit;
  logic       err_sync, err_tmo, err_ovf, err_late;
  logic [1:0] err_inc;
  logic [8:0] err_sum;
  logic       tmo_run, tmo_expire;

  assign tmo_run = en && ((state == S_B1) || (state == S_B2));

  ps2_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .load   (en && byte_valid),
    .clear  (!en),
    .run    (tmo_run),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    lat0       = 1'b0;
    lat1       = 1'b0;
    lat2       = 1'b0;
    commit     = 1'b0;
    err_sync   = 1'b0;
    err_tmo    = 1'b0;
    err_late   = 1'b0;
    if (!en) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (byte_valid) begin
            if (byte_data[SYNC_BIT]) begin
              lat0       = 1'b1;
              next_state = S_B1;
            end else begin
              err_sync = 1'b1;
            end
          end
        end
        S_B1: begin
          // A byte arriving in the expiry cycle is kept.
          if (byte_valid) begin
            lat1       = 1'b1;
            next_state = S_B2;
          end else if (tmo_expire) begin
            err_tmo    = 1'b1;
            next_state = S_IDLE;
          end
        end
        S_B2: begin
          if (byte_valid) begin
            lat2       = 1'b1;
            next_state = S_COMMIT;
          end else if (tmo_expire) begin
            err_tmo    = 1'b1;
            next_state = S_IDLE;
          end
        end
        S_COMMIT: begin
          commit     = 1'b1;
          err_late   = byte_valid;
          next_state = S_IDLE;
        end
        default: next_state = S_IDLE;
      endcase
    end
  end

  assign err_ovf = commit && (b0[XOVF] || b0[YOVF]);
  // Overflow and a stray byte in S_COMMIT can coincide; count both.
  assign err_inc = 2'(err_sync) + 2'(err_tmo) + 2'(err_ovf) + 2'(err_late);
  assign err_sum = {1'b0, err_cnt} + 9'(err_inc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b0 <= '0;
      b1 <= '0;
      b2 <= '0;
    end else begin
      if (lat0) b0 <= byte_data;
      if (lat1) b1 <= byte_data;
      if (lat2) b2 <= byte_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_axis       <= '0;
      y_axis       <= '0;
      buttons      <= '0;
      package_done <= 1'b0;
    end else begin
      package_done <= commit;
      if (commit) begin
        x_axis  <= b0[XOVF] ? 9'd0 : {b0[XSIGN], b1};
        y_axis  <= b0[YOVF] ? 9'd0 : {b0[YSIGN], b2};
        buttons <= b0[2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else if (clr_cnt) begin
      pkt_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (commit) pkt_cnt <= pkt_cnt + 1'b1;
      err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end

endmodule

// File: tb/tb_ps2_packet_sequencer.sv
module tb_ps2_packet_sequencer;

  localparam int T  = 300;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          clr_cnt = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic [8:0]    x_axis, y_axis;
  logic [2:0]    buttons;
  logic          package_done;
  logic [CW-1:0] pkt_cnt;
  logic [7:0]    err_cnt;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int z = 0;

  ps2_packet_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .clr_cnt      (clr_cnt),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .x_axis       (x_axis),
    .y_axis       (y_axis),
    .buttons      (buttons),
    .package_done (package_done),
    .pkt_cnt      (pkt_cnt),
    .err_cnt      (err_cnt)
  );

  always #5 clk = ~clk;

  // Accumulator model: z follows x+y on every accepted packet.
  always @(negedge clk) begin
    if (package_done) begin
      done_cnt++;
      z += int'($signed(x_axis)) + int'($signed(y_axis));
    end
  end

  typedef struct {
    logic [7:0] b0, b1, b2;
    logic [8:0] x, y;
    logic [2:0] btn;
    int         derr;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    byte_data  = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Called right after the last byte's strobe edge: done must rise
  // exactly two cycles after the strobe and last one cycle.
  task automatic finish_check(input logic [8:0] ex, input logic [8:0] ey, input logic [2:0] eb);
    @(negedge clk);
    chk("done_early", 32'(package_done), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(package_done), 32'd1);
    chk("x_axis", 32'(x_axis), 32'(ex));
    chk("y_axis", 32'(y_axis), 32'(ey));
    chk("buttons", 32'(buttons), 32'(eb));
    @(negedge clk);
    chk("done_width", 32'(package_done), 32'd0);
    tick();
  endtask

  task automatic run_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [8:0] ex, input logic [8:0] ey, input logic [2:0] eb,
                            input int derr, input int gap);
    logic [CW-1:0] p0, dp;
    logic [7:0]    e0, de;
    int            d0;
    p0 = pkt_cnt;
    e0 = err_cnt;
    d0 = done_cnt;
    send(b0, gap);
    send(b1, gap);
    send(b2, 0);
    finish_check(ex, ey, eb);
    dp = pkt_cnt - p0;
    de = err_cnt - e0;
    chk("pkt_delta", 32'(dp), 32'd1);
    chk("err_delta", 32'(de), 32'(derr));
    chk("done_count", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    logic [7:0] e0;
    int         d0, z0;

    vt[0] = '{8'h48, 8'h7F, 8'h04, 9'h000, 9'h004, 3'd0, 1};
    vt[1] = '{8'h88, 8'h10, 8'h20, 9'h010, 9'h000, 3'd0, 1};
    vt[2] = '{8'h0F, 8'h80, 8'h7F, 9'h080, 9'h07F, 3'd7, 0};
    vt[3] = '{8'h08, 8'h01, 8'h01, 9'h001, 9'h001, 3'd0, 0};
    vt[4] = '{8'hC8, 8'h12, 8'h34, 9'h000, 9'h000, 3'd0, 1};
    vt[5] = '{8'h2A, 8'h40, 8'h80, 9'h040, 9'h180, 3'd2, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", 32'(x_axis), 32'd0);
    chk("rst_y", 32'(y_axis), 32'd0);
    chk("rst_btn", 32'(buttons), 32'd0);
    chk("rst_done", 32'(package_done), 32'd0);
    chk("rst_pkt", 32'(pkt_cnt), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    rst = 1'b1;
    en  = 1'b1;
    tick();

    run_packet(8'h08, 8'h05, 8'h03, 9'h005, 9'h003, 3'd0, 0, 100);
    chk("pkt_first", 32'(pkt_cnt), 32'd1);

    for (int i = 0; i < 6; i++)
      run_packet(vt[i].b0, vt[i].b1, vt[i].b2, vt[i].x, vt[i].y, vt[i].btn, vt[i].derr, 10);

    z0 = z;
    run_packet(8'h39, 8'hFE, 8'hFF, 9'h1FE, 9'h1FF, 3'd1, 0, 100);
    chk("z_delta", 32'(z - z0), 32'hFFFF_FFFD);

    // clear, then bad sync byte
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_pkt", 32'(pkt_cnt), 32'd0);
    chk("clr_err", 32'(err_cnt), 32'd0);
    d0 = done_cnt;
    send(8'h00, 5);
    chk("sync_err", 32'(err_cnt), 32'd1);
    chk("sync_nodone", 32'(done_cnt), 32'(d0));
    run_packet(8'h08, 8'h01, 8'h01, 9'h001, 9'h001, 3'd0, 0, 100);
    chk("sync_pkt", 32'(pkt_cnt), 32'd1);

    // timeout with partial packet
    e0 = err_cnt;
    d0 = done_cnt;
    send(8'h08, 100);
    send(8'h10, 0);
    repeat (T - 1) tick();
    chk("tmo_before", 32'(err_cnt), 32'(e0));
    tick();
    chk("tmo_err", 32'(err_cnt), 32'(e0 + 8'd1));
    chk("tmo_nodone", 32'(done_cnt), 32'(d0));
    run_packet(8'h08, 8'h02, 8'h02, 9'h002, 9'h002, 3'd0, 0, 100);

    // byte in the expiry cycle is accepted
    e0 = err_cnt;
    send(8'h08, 20);
    send(8'h10, 0);
    repeat (T - 1) tick();
    send(8'h20, 0);
    finish_check(9'h010, 9'h020, 3'd0);
    chk("expiry_err", 32'(err_cnt), 32'(e0));

    // en low mid-packet drops it; outputs hold
    e0 = err_cnt;
    d0 = done_cnt;
    send(8'h08, 10);
    send(8'h05, 10);
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    send(8'h03, 5);
    chk("en_err", 32'(err_cnt), 32'(e0 + 8'd1));
    chk("en_nodone", 32'(done_cnt), 32'(d0));
    chk("en_hold_x", 32'(x_axis), 32'h010);
    en = 1'b0;
    send(8'h00, 2);
    chk("en_ignore", 32'(err_cnt), 32'(e0 + 8'd1));
    en = 1'b1;
    tick();

    // reset mid-packet
    send(8'h08, 10);
    send(8'h01, 10);
    rst = 1'b0;
    tick();
    chk("mrst_x", 32'(x_axis), 32'd0);
    chk("mrst_y", 32'(y_axis), 32'd0);
    chk("mrst_pkt", 32'(pkt_cnt), 32'd0);
    chk("mrst_err", 32'(err_cnt), 32'd0);
    rst = 1'b1;
    tick();
    run_packet(8'h08, 8'h01, 8'h02, 9'h001, 9'h002, 3'd0, 0, 10);
    chk("mrst_pkt_after", 32'(pkt_cnt), 32'd1);

    // err_cnt saturation
    repeat (260) send(8'h00, 1);
    chk("err_sat", 32'(err_cnt), 32'd255);
    send(8'h00, 2);
    chk("err_sat_hold", 32'(err_cnt), 32'd255);

    // clr_cnt beats a same-cycle error
    byte_data  = 8'h00;
    byte_valid = 1'b1;
    clr_cnt    = 1'b1;
    tick();
    byte_valid = 1'b0;
    clr_cnt    = 1'b0;
    tick();
    chk("clr_prio", 32'(err_cnt), 32'd0);

    // pkt_cnt wrap
    for (int i = 0; i < 15; i++) begin
      send(8'h08, 2);
      send(8'h01, 2);
      send(8'h01, 4);
    end
    chk("pkt_15", 32'(pkt_cnt), 32'd15);
    send(8'h08, 2);
    send(8'h01, 2);
    send(8'h01, 4);
    chk("pkt_wrap", 32'(pkt_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
